// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target bridging SPI transactions to a small byte register file.
//
// All SPI pins are oversampled in the CLK domain; no logic is clocked by SCK.
//
// Ports:
//   CLK      in   sole clock
//   nRESET   in   asynchronous active-low reset
//   SCK      in   SPI clock from the master (asynchronous)
//   MOSI     in   SPI data from the master (asynchronous)
//   nSS      in   target select, active low (asynchronous)
//   MISO     out  SPI data to the master
//   MISO_OE  out  high while selected; pad drives MISO only when set
//   LADDR    in   local read address
//   LDOUT    out  combinational read of regs[LADDR]
//   WSTB     out  one-CLK pulse per committed SPI write
//   WADDR    out  address of the last committed write
//
// Commands: 8'h03 addr data... = read, 8'h02 addr data... = write, 8'h9F = ID.
module spi_target #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  ID_BYTE = 8'hA5
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          SCK,
    input  logic          MOSI,
    input  logic          nSS,
    output logic          MISO,
    output logic          MISO_OE,
    input  logic [AW-1:0] LADDR,
    output logic [7:0]    LDOUT,
    output logic          WSTB,
    output logic [AW-1:0] WADDR
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRd,
        StWr,
        StId,
        StIgn
    } state_t;

    // Synchronisers: [0],[1] resolve metastability, [2] is the previous value for edges.
    logic [2:0]    sck_q;
    logic [2:0]    mosi_q;
    logic [2:0]    nss_q;
    logic [1:0]    sync_cnt_q;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [7:0]    rx_q;
    logic [7:0]    tx_q;
    logic [AW-1:0] addr_q;
    logic          is_read_q;
    logic          miso_q;
    logic          miso_oe_q;
    logic          wstb_q;
    logic [AW-1:0] waddr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    regs_q [DEPTH];

    logic          sck_rise;
    logic          sck_fall;
    logic          sel;
    logic          sel_rise;
    logic          sync_ok;
    logic          mosi_bit;
    logic [7:0]    rx_byte;
    logic          byte_done;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] rx_addr;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sck_q      <= 3'b000;
            mosi_q     <= 3'b000;
            nss_q      <= 3'b111;
            sync_cnt_q <= 2'd0;
        end else begin
            sck_q  <= {sck_q[1:0], SCK};
            mosi_q <= {mosi_q[1:0], MOSI};
            nss_q  <= {nss_q[1:0], nSS};
            if (!sync_ok) begin
                sync_cnt_q <= sync_cnt_q + 2'd1;
            end
        end
    end

    // After reset the synchroniser still holds its reset value of nSS=1; a select is
    // only trusted once every stage holds a real sample, so a master that kept nSS low
    // across reset is ignored until it deselects and selects again.
    assign sync_ok   = (sync_cnt_q == 2'd3);
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign sel       = ~nss_q[1];
    assign sel_rise  = sel & nss_q[2] & sync_ok;
    // MOSI one stage older than the SCK sample that detects the rise: settled before it.
    assign mosi_bit  = mosi_q[2];
    assign rx_byte   = {rx_q[6:0], mosi_bit};
    assign byte_done = sck_rise & (cnt_q == 3'd7);
    assign addr_inc  = addr_q + 1'b1;
    assign rx_addr   = rx_byte[AW-1:0];

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            miso_q    <= 1'b1;
            miso_oe_q <= 1'b0;
            wstb_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 8'h00;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wstb_q <= 1'b0;
            // Commit is one cycle behind WSTB so LDOUT shows the old value in the WSTB cycle.
            if (wstb_q) begin
                regs_q[waddr_q] <= wdata_q;
            end

            if (state_q == StIdle) begin
                if (sel_rise) begin
                    state_q   <= StCmd;
                    miso_oe_q <= 1'b1;
                    miso_q    <= 1'b1;
                    tx_q      <= 8'hFF;
                    cnt_q     <= 3'd0;
                    rx_q      <= 8'h00;
                end
            end else if (!sel) begin
                // Deselect beats a coincident SCK edge; a partial byte is dropped.
                state_q   <= StIdle;
                miso_oe_q <= 1'b0;
                miso_q    <= 1'b1;
            end else begin
                if (sck_fall) begin
                    tx_q   <= {tx_q[6:0], 1'b1};
                    miso_q <= tx_q[7];
                end
                if (sck_rise) begin
                    cnt_q <= cnt_q + 3'd1;
                    rx_q  <= rx_byte;
                end
                if (byte_done) begin
                    unique case (state_q)
                        StCmd: begin
                            tx_q <= 8'hFF;
                            case (rx_byte)
                                8'h03: begin
                                    state_q   <= StAddr;
                                    is_read_q <= 1'b1;
                                end
                                8'h02: begin
                                    state_q   <= StAddr;
                                    is_read_q <= 1'b0;
                                end
                                8'h9F: begin
                                    state_q <= StId;
                                    tx_q    <= ID_BYTE;
                                end
                                default: state_q <= StIgn;
                            endcase
                        end
                        StAddr: begin
                            addr_q <= rx_addr;
                            if (is_read_q) begin
                                tx_q    <= regs_q[rx_addr];
                                state_q <= StRd;
                            end else begin
                                tx_q    <= 8'hFF;
                                state_q <= StWr;
                            end
                        end
                        StRd: begin
                            addr_q <= addr_inc;
                            tx_q   <= regs_q[addr_inc];
                        end
                        StWr: begin
                            wstb_q  <= 1'b1;
                            waddr_q <= addr_q;
                            wdata_q <= rx_byte;
                            addr_q  <= addr_inc;
                        end
                        StId: begin
                            tx_q <= 8'h00;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign MISO    = miso_q;
    assign MISO_OE = miso_oe_q;
    assign WSTB    = wstb_q;
    assign WADDR   = waddr_q;
    assign LDOUT   = regs_q[LADDR];

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: bit-banged SPI master driving spi_target, with a write scoreboard.
module tb_spi_target;

    localparam int HALF = 5;  // CLK cycles per SCK half-period

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       SCK;
    logic       MOSI;
    logic       nSS;
    logic       MISO;
    logic       MISO_OE;
    logic [3:0] LADDR;
    logic [7:0] LDOUT;
    logic       WSTB;
    logic [3:0] WADDR;

    int checks = 0;
    int failures = 0;

    spi_target #(
        .DEPTH  (16),
        .AW     (4),
        .ID_BYTE(8'hA5)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .SCK    (SCK),
        .MOSI   (MOSI),
        .nSS    (nSS),
        .MISO   (MISO),
        .MISO_OE(MISO_OE),
        .LADDR  (LADDR),
        .LDOUT  (LDOUT),
        .WSTB   (WSTB),
        .WADDR  (WADDR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] mosi;
        logic [31:0] miso;
    } vec_t;

    logic [7:0]  mem_model [16];
    logic [11:0] exp_w [$];
    logic [7:0]  exp_miso [$];
    bit          chk_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: WADDR against the scoreboard, LDOUT old in WSTB cycle, new after.
    always @(negedge CLK) begin
        logic [11:0] w;
        if (chk_next) begin
            check("ldout_after_write", {24'b0, LDOUT}, {24'b0, mem_model[LADDR]});
            chk_next = 1'b0;
        end
        if (WSTB === 1'b1) begin
            if (exp_w.size() == 0) begin
                check("wstb_unexpected", {31'b0, WSTB}, 32'd0);
            end else begin
                w = exp_w.pop_front();
                check("waddr", {28'b0, WADDR}, {28'b0, w[11:8]});
                check("ldout_in_wstb_cycle", {24'b0, LDOUT}, {24'b0, mem_model[LADDR]});
                mem_model[w[11:8]] = w[7:0];
                chk_next = 1'b1;
            end
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = tx[i];
            repeat (HALF) @(negedge CLK);
            SCK = 1'b1;
            rx[i] = MISO;
            repeat (HALF) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    task automatic select();
        nSS = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic deselect();
        repeat (HALF) @(negedge CLK);
        nSS = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    // Sends one full byte and compares the returned MISO byte with the scoreboard.
    task automatic xfer(input string name, input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] rx;
        logic [7:0] e;
        exp_miso.push_back(exp);
        spi_bits(tx, 8, rx);
        e = exp_miso.pop_front();
        check(name, {24'b0, rx}, {24'b0, e});
        check({name, "_oe"}, {31'b0, MISO_OE}, 32'd1);
    endtask

    task automatic ldout_is(input logic [3:0] a, input logic [7:0] exp);
        @(negedge CLK);
        LADDR = a;
        #1;
        check($sformatf("ldout[%0d]", a), {24'b0, LDOUT}, {24'b0, exp});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [6];
        vec_t       v;
        logic [7:0] b;
        logic [7:0] rx;
        logic [3:0] wa;

        tbl[0] = {3'd4, 32'h02035AC3, 32'hFFFFFFFF};
        tbl[1] = {3'd4, 32'h03030000, 32'hFFFF5AC3};
        tbl[2] = {3'd4, 32'h020F1122, 32'hFFFFFFFF};
        tbl[3] = {3'd4, 32'h030F0000, 32'hFFFF1122};
        tbl[4] = {3'd3, 32'h9F000000, 32'hFFA50000};
        tbl[5] = {3'd2, 32'h47000000, 32'hFFFF0000};

        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
        nRESET = 1'b0;
        SCK    = 1'b0;
        MOSI   = 1'b0;
        nSS    = 1'b1;
        LADDR  = 4'd4;
        repeat (3) @(negedge CLK);
        check("rst_miso", {31'b0, MISO}, 32'd1);
        check("rst_miso_oe", {31'b0, MISO_OE}, 32'd0);
        check("rst_wstb", {31'b0, WSTB}, 32'd0);
        check("rst_waddr", {28'b0, WADDR}, 32'd0);
        check("rst_ldout", {24'b0, LDOUT}, 32'd0);
        nRESET = 1'b1;
        repeat (5) @(negedge CLK);

        for (int t = 0; t < 6; t++) begin
            v = tbl[t];
            select();
            for (int i = 0; i < int'(v.n); i++) begin
                b = v.mosi[31-8*i -: 8];
                if (v.mosi[31:24] == 8'h02 && i >= 2) begin
                    wa = v.mosi[19:16] + 4'(i - 2);
                    exp_w.push_back({wa, b});
                end
                xfer($sformatf("t%0d_miso%0d", t, i), b, v.miso[31-8*i -: 8]);
            end
            deselect();
            check($sformatf("t%0d_oe_idle", t), {31'b0, MISO_OE}, 32'd0);
            check($sformatf("t%0d_miso_idle", t), {31'b0, MISO}, 32'd1);
            check($sformatf("t%0d_writes_seen", t), exp_w.size(), 32'd0);
        end

        ldout_is(4'd3, 8'h5A);
        ldout_is(4'd4, 8'hC3);
        ldout_is(4'd15, 8'h11);
        ldout_is(4'd0, 8'h22);

        // Abort: only 5 data bits before deselect, so no write may happen.
        select();
        xfer("abort_cmd", 8'h02, 8'hFF);
        xfer("abort_addr", 8'h05, 8'hFF);
        spi_bits(8'hE7, 5, rx);
        deselect();
        ldout_is(4'd5, 8'h00);
        check("abort_oe_idle", {31'b0, MISO_OE}, 32'd0);

        // Next transaction after the abort decodes normally.
        select();
        xfer("post_abort_cmd", 8'h03, 8'hFF);
        xfer("post_abort_addr", 8'h03, 8'hFF);
        xfer("post_abort_d0", 8'h00, 8'h5A);
        deselect();

        // Reset in the middle of a write, after 4 data bits.
        select();
        xfer("rst_wr_cmd", 8'h02, 8'hFF);
        xfer("rst_wr_addr", 8'h06, 8'hFF);
        spi_bits(8'hAB, 4, rx);
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        check("midrst_miso", {31'b0, MISO}, 32'd1);
        check("midrst_miso_oe", {31'b0, MISO_OE}, 32'd0);
        check("midrst_wstb", {31'b0, WSTB}, 32'd0);
        check("midrst_waddr", {28'b0, WADDR}, 32'd0);
        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
        ldout_is(4'd3, 8'h00);
        ldout_is(4'd0, 8'h00);
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        repeat (4) @(negedge CLK);
        // nSS still low: these SCK edges must do nothing.
        for (int k = 0; k < 3; k++) begin
            spi_bits(8'h02, 8, rx);
            check($sformatf("held_sel_oe%0d", k), {31'b0, MISO_OE}, 32'd0);
            check($sformatf("held_sel_miso%0d", k), {31'b0, MISO}, 32'd1);
        end
        deselect();
        check("held_sel_waddr", {28'b0, WADDR}, 32'd0);

        // Fresh select after reset works, and regs read back as cleared.
        select();
        xfer("post_rst_id_cmd", 8'h9F, 8'hFF);
        xfer("post_rst_id", 8'h00, 8'hA5);
        deselect();
        select();
        xfer("post_rst_rd_cmd", 8'h03, 8'hFF);
        xfer("post_rst_rd_addr", 8'h03, 8'hFF);
        xfer("post_rst_rd_d0", 8'h00, 8'h00);
        deselect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
